pdm_capture_writer: RTL

- Receive-side counterpart of the audio output path. Generates the on-board microphone clock, samples the 1-bit PDM mic stream, and decimates it with a boxcar (ones-count) filter into signed 16-bit PCM.
- Writes each sample into the DelayBuffer write port (port A) at a wrapping address. AudioOutput reads the same buffer on port B.
- Runs entirely in the clk_100MHz domain.

---
 rtl/pdm_capture_writer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pdm_capture_writer.sv
// PDM microphone capture: generates mic_clk, samples the 1-bit PDM stream,
// decimates it with a boxcar (ones-count) filter and writes signed 16-bit
// PCM samples into the DelayBuffer write port at a wrapping address.
module pdm_capture_writer #(
  parameter int CLK_HALF = 16,  // clk cycles per mic_clk half-period
  parameter int DECIM    = 64,  // PDM bits per PCM sample (power of 2, 4..256)
  parameter int SHIFT    = 10,  // left shift applied to the centred count
  parameter int ADDR_W   = 16   // DelayBuffer address width
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mic_data,
  output logic              mic_clk,
  output logic              mic_lrsel,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              buf_wrapped
);

  localparam int DIV_W = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int BIT_W = $clog2(DECIM);
  localparam int CNT_W = BIT_W + 1;  // holds a full count of DECIM

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_HALF - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DECIM - 1);
  localparam logic signed [47:0] HALF_CNT = 48'(DECIM / 2);
  localparam logic signed [47:0] SAT_MAX  = 48'sd32767;
  localparam logic signed [47:0] SAT_MIN  = -48'sd32768;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    WRITE
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        sync_reg;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic              mic_clk_reg, mic_clk_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]  acc_reg, acc_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [15:0]       wr_data_reg, wr_data_next;
  logic              wrapped_reg, wrapped_next;

  logic              rise;
  logic [CNT_W-1:0]  final_cnt;
  logic signed [47:0] centred;
  logic signed [47:0] scaled;
  logic [15:0]       sample;

  // Two-flop synchronizer for the asynchronous PDM input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], mic_data};
    end
  end

  // A rise is the cycle in which the divider is about to drive mic_clk 0->1.
  assign rise = (state_reg != IDLE) && (div_cnt_reg == DIV_LAST) && !mic_clk_reg;

  // Count including the bit taken on this rise; becomes the sample on the last bit.
  always_comb begin
    final_cnt = acc_reg + CNT_W'(sync_reg[1]);
    centred   = $signed({{(48 - CNT_W){1'b0}}, final_cnt}) - HALF_CNT;
    scaled    = centred <<< SHIFT;
    if (scaled > SAT_MAX) begin
      sample = 16'h7FFF;
    end else if (scaled < SAT_MIN) begin
      sample = 16'h8000;
    end else begin
      sample = scaled[15:0];
    end
  end

  // Capture FSM: accumulate DECIM bits, then one write cycle, then repeat.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    acc_next     = acc_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    wrapped_next = wrapped_reg;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next   = CAPTURE;
          bit_cnt_next = '0;
          acc_next     = '0;
        end
      end
      CAPTURE: begin
        if (!enable) begin
          // Partial window is thrown away; address and wrap flag are kept.
          state_next   = IDLE;
          bit_cnt_next = '0;
          acc_next     = '0;
        end else if (rise) begin
          acc_next     = final_cnt;
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          if (bit_cnt_reg == BIT_LAST) begin
            state_next   = WRITE;
            wr_en_next   = 1'b1;
            wr_data_next = sample;
          end
        end
      end
      WRITE: begin
        wr_addr_next = wr_addr_reg + ADDR_W'(1);
        if (wr_addr_reg == {ADDR_W{1'b1}}) begin
          wrapped_next = 1'b1;
        end
        bit_cnt_next = '0;
        acc_next     = '0;
        state_next   = enable ? CAPTURE : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // mic_clk divider: free-running while capturing, parked low in (or on the way to) IDLE.
  always_comb begin
    div_cnt_next = div_cnt_reg;
    mic_clk_next = mic_clk_reg;
    if (state_reg == IDLE || state_next == IDLE) begin
      div_cnt_next = '0;
      mic_clk_next = 1'b0;
    end else if (div_cnt_reg == DIV_LAST) begin
      div_cnt_next = '0;
      mic_clk_next = ~mic_clk_reg;
    end else begin
      div_cnt_next = div_cnt_reg + DIV_W'(1);
    end
  end

  // State and output registers; reset wins over everything, including WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      div_cnt_reg <= '0;
      mic_clk_reg <= 1'b0;
      bit_cnt_reg <= '0;
      acc_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      wrapped_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_cnt_reg <= div_cnt_next;
      mic_clk_reg <= mic_clk_next;
      bit_cnt_reg <= bit_cnt_next;
      acc_reg     <= acc_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      wrapped_reg <= wrapped_next;
    end
  end

  assign mic_clk     = mic_clk_reg;
  assign mic_lrsel   = 1'b1;
  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign buf_wrapped = wrapped_reg;

endmodule
